// File: rtl/ddrx_addr_cmd_lp_if.sv
// Controller-side command bundle for the AFI address/command decoder.
interface ddrx_addr_cmd_lp_if #(
    parameter int CS_W  = 1,
    parameter int BA_W  = 3,
    parameter int ROW_W = 13,
    parameter int COL_W = 10
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_type;
    logic             cmd_slot;
    logic [CS_W-1:0]  to_chip;
    logic [BA_W-1:0]  to_bank_addr;
    logic [ROW_W-1:0] to_row_addr;
    logic [COL_W-1:0] to_col_addr;
    logic             do_auto_precharge;
    logic             do_burst_chop;
    logic             zq_long;
    logic             cmd_err;

    modport master (
        output cmd_valid, cmd_type, cmd_slot, to_chip, to_bank_addr,
        output to_row_addr, to_col_addr, do_auto_precharge,
        output do_burst_chop, zq_long,
        input  cmd_ready, cmd_err
    );

    modport slave (
        input  cmd_valid, cmd_type, cmd_slot, to_chip, to_bank_addr,
        input  to_row_addr, to_col_addr, do_auto_precharge,
        input  do_burst_chop, zq_long,
        output cmd_ready, cmd_err
    );
endinterface

// File: rtl/ddrx_addr_cmd_lp.sv
// DDR2/DDR3 AFI address/command decoder with per-chip power-down and
// self-refresh tracking, residency and exit-recovery timers.
module ddrx_addr_cmd_lp #(
    parameter int MEM_IF_CS_WIDTH   = 1,
    parameter int MEM_IF_ADDR_WIDTH = 13,
    parameter int MEM_IF_ROW_WIDTH  = 13,
    parameter int MEM_IF_COL_WIDTH  = 10,
    parameter int MEM_IF_BA_WIDTH   = 3,
    parameter     MEM_TYPE          = "DDR2",
    parameter int DWIDTH_RATIO      = 2,
    parameter int CTL_OUTPUT_REGD   = 0,
    parameter int CKE_MIN_CYCLES    = 3,
    parameter int TXP_CYCLES        = 3,
    parameter int TXS_CYCLES        = 256
) (
    input  logic ctl_clk,
    input  logic ctl_reset_n,
    input  logic ctl_cal_success,
    ddrx_addr_cmd_lp_if.slave cmd,
    output logic [2*MEM_IF_CS_WIDTH-1:0] chip_lp_state,
    output logic [MEM_IF_CS_WIDTH*DWIDTH_RATIO/2-1:0] afi_cke,
    output logic [MEM_IF_CS_WIDTH*DWIDTH_RATIO/2-1:0] afi_cs_n,
    output logic [DWIDTH_RATIO/2-1:0] afi_ras_n,
    output logic [DWIDTH_RATIO/2-1:0] afi_cas_n,
    output logic [DWIDTH_RATIO/2-1:0] afi_we_n,
    output logic [DWIDTH_RATIO/2-1:0] afi_rst_n,
    output logic [MEM_IF_BA_WIDTH*DWIDTH_RATIO/2-1:0] afi_ba,
    output logic [MEM_IF_ADDR_WIDTH*DWIDTH_RATIO/2-1:0] afi_addr
);
    localparam int CS = MEM_IF_CS_WIDTH;
    localparam int AW = MEM_IF_ADDR_WIDTH;
    localparam int BW = MEM_IF_BA_WIDTH;
    localparam int R  = DWIDTH_RATIO / 2;
    localparam bit DDR3 = (MEM_TYPE == "DDR3");
    localparam int CM0 = (TXS_CYCLES > TXP_CYCLES) ? TXS_CYCLES : TXP_CYCLES;
    localparam int CMX = (CM0 > CKE_MIN_CYCLES) ? CM0 : CKE_MIN_CYCLES;
    localparam int CW  = $clog2(CMX + 1);

    localparam logic [1:0] ST_ACTIVE = 2'd0;
    localparam logic [1:0] ST_PDN    = 2'd1;
    localparam logic [1:0] ST_SRF    = 2'd2;

    localparam logic [3:0] C_NOP  = 4'd0;
    localparam logic [3:0] C_ACT  = 4'd1;
    localparam logic [3:0] C_RD   = 4'd2;
    localparam logic [3:0] C_WR   = 4'd3;
    localparam logic [3:0] C_PRE  = 4'd4;
    localparam logic [3:0] C_PREA = 4'd5;
    localparam logic [3:0] C_REF  = 4'd6;
    localparam logic [3:0] C_MRS  = 4'd7;
    localparam logic [3:0] C_ZQ   = 4'd8;
    localparam logic [3:0] C_PDN  = 4'd9;
    localparam logic [3:0] C_SRF  = 4'd10;
    localparam logic [3:0] C_EXIT = 4'd11;

    // Column bits above 9 skip addr[10] (auto-precharge); DDR3 also skips addr[12].
    function automatic logic [AW-1:0] col_map(
        input logic [MEM_IF_COL_WIDTH-1:0] col,
        input logic ap,
        input logic bc
    );
        logic [AW-1:0] a;
        int k;
        a = '0;
        for (int j = 0; j < MEM_IF_COL_WIDTH; j++) begin
            if (j < 10)              k = j;
            else if (DDR3 && j == 10) k = 11;
            else if (DDR3)           k = j + 2;
            else                     k = j + 1;
            if (k < AW) a[k] = col[j];
        end
        a[10] = ap;
        if (DDR3) a[12] = ~bc;
        return a;
    endfunction

    logic [2*CS-1:0] lp_q, lp_d;
    logic [CW-1:0]   res_q, res_d, rec_q, rec_d;
    logic            err_q, err_d, run_q, run_d;
    logic [CS-1:0]   in_lp, in_srf;
    logic            ready, acc, is_nop, illegal, go, ent_go, exit_go, slot;

    logic [CS-1:0] c_cs_n;
    logic          c_ras_n, c_cas_n, c_we_n;
    logic [BW-1:0] c_ba;
    logic [AW-1:0] c_addr;

    logic [CS*R-1:0] cke_d, cs_n_d;
    logic [R-1:0]    ras_n_d, cas_n_d, we_n_d;
    logic [BW*R-1:0] ba_d;
    logic [AW*R-1:0] addr_d;

    always_comb begin
        in_lp  = '0;
        in_srf = '0;
        for (int i = 0; i < CS; i++) begin
            in_lp[i]  = lp_q[2*i +: 2] != ST_ACTIVE;
            in_srf[i] = lp_q[2*i +: 2] == ST_SRF;
        end
    end

    assign ready   = ctl_cal_success & run_q & (res_q == '0) & (rec_q == '0);
    assign acc     = cmd.cmd_valid & ready;
    assign is_nop  = (cmd.cmd_type == C_NOP) | (cmd.cmd_type >= 4'd12);
    assign illegal = ~is_nop & ((cmd.to_chip == '0)
                   | ((cmd.cmd_type != C_EXIT) & |(cmd.to_chip & in_lp))
                   | ((cmd.cmd_type == C_EXIT) & |(cmd.to_chip & ~in_lp))
                   | ((cmd.cmd_type == C_ZQ) & !DDR3));
    assign go      = acc & ~is_nop & ~illegal;
    assign ent_go  = go & ((cmd.cmd_type == C_PDN) | (cmd.cmd_type == C_SRF));
    assign exit_go = go & (cmd.cmd_type == C_EXIT);
    assign slot    = (R == 2) ? cmd.cmd_slot : 1'b0;

    always_comb begin
        c_cs_n  = '1;
        c_ras_n = 1'b1;
        c_cas_n = 1'b1;
        c_we_n  = 1'b1;
        c_ba    = '0;
        c_addr  = '0;
        if (go) begin
            case (cmd.cmd_type)
                C_ACT: begin
                    c_cs_n = ~cmd.to_chip; c_ras_n = 1'b0;
                    c_ba = cmd.to_bank_addr;
                    c_addr[MEM_IF_ROW_WIDTH-1:0] = cmd.to_row_addr;
                end
                C_RD, C_WR: begin
                    c_cs_n = ~cmd.to_chip; c_cas_n = 1'b0;
                    c_we_n = (cmd.cmd_type != C_WR);
                    c_ba = cmd.to_bank_addr;
                    c_addr = col_map(cmd.to_col_addr, cmd.do_auto_precharge,
                                     cmd.do_burst_chop);
                end
                C_PRE, C_PREA: begin
                    c_cs_n = ~cmd.to_chip; c_ras_n = 1'b0; c_we_n = 1'b0;
                    c_ba = cmd.to_bank_addr;
                    c_addr[10] = (cmd.cmd_type == C_PREA);
                end
                C_REF, C_SRF: begin
                    c_cs_n = ~cmd.to_chip; c_ras_n = 1'b0; c_cas_n = 1'b0;
                end
                C_MRS: begin
                    c_cs_n = ~cmd.to_chip; c_ras_n = 1'b0;
                    c_cas_n = 1'b0; c_we_n = 1'b0;
                    c_ba = cmd.to_bank_addr;
                    c_addr[MEM_IF_ROW_WIDTH-1:0] = cmd.to_row_addr;
                end
                C_ZQ: begin
                    c_cs_n = ~cmd.to_chip; c_we_n = 1'b0;
                    c_addr[10] = cmd.zq_long;
                end
                default: ;
            endcase
        end
    end

    // CKE changes from the command's slot phase onward; earlier phases keep the old level.
    always_comb begin
        cke_d   = '1;
        cs_n_d  = '1;
        ras_n_d = '1;
        cas_n_d = '1;
        we_n_d  = '1;
        ba_d    = '0;
        addr_d  = '0;
        for (int p = 0; p < R; p++) begin
            if ((R == 1) || (slot == 1'(p))) begin
                cs_n_d[p*CS +: CS] = c_cs_n;
                ras_n_d[p]         = c_ras_n;
                cas_n_d[p]         = c_cas_n;
                we_n_d[p]          = c_we_n;
                ba_d[p*BW +: BW]   = c_ba;
                addr_d[p*AW +: AW] = c_addr;
            end
            for (int i = 0; i < CS; i++) begin
                cke_d[p*CS+i] = ~in_lp[i];
                if (cmd.to_chip[i] && (p >= int'(slot))) begin
                    if (ent_go)  cke_d[p*CS+i] = 1'b0;
                    if (exit_go) cke_d[p*CS+i] = 1'b1;
                end
                if (!ctl_cal_success) cke_d[p*CS+i] = 1'b1;
            end
        end
    end

    always_comb begin
        lp_d  = lp_q;
        res_d = (res_q != '0) ? res_q - CW'(1) : res_q;
        rec_d = (rec_q != '0) ? rec_q - CW'(1) : rec_q;
        err_d = acc & illegal;
        run_d = 1'b1;
        if (!ctl_cal_success) begin
            lp_d  = '0;
            res_d = '0;
            rec_d = '0;
            err_d = 1'b0;
        end else if (ent_go) begin
            for (int i = 0; i < CS; i++)
                if (cmd.to_chip[i])
                    lp_d[2*i +: 2] = (cmd.cmd_type == C_SRF) ? ST_SRF : ST_PDN;
            res_d = CW'(CKE_MIN_CYCLES);
        end else if (exit_go) begin
            for (int i = 0; i < CS; i++)
                if (cmd.to_chip[i]) lp_d[2*i +: 2] = ST_ACTIVE;
            rec_d = |(cmd.to_chip & in_srf) ? CW'(TXS_CYCLES) : CW'(TXP_CYCLES);
        end
    end

    always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
        if (!ctl_reset_n) begin
            lp_q  <= '0;
            res_q <= '0;
            rec_q <= '0;
            err_q <= 1'b0;
            run_q <= 1'b0;
        end else begin
            lp_q  <= lp_d;
            res_q <= res_d;
            rec_q <= rec_d;
            err_q <= err_d;
            run_q <= run_d;
        end
    end

    assign cmd.cmd_ready = ready;
    assign cmd.cmd_err   = err_q;
    assign chip_lp_state = lp_q;
    assign afi_rst_n     = '1;

    if (CTL_OUTPUT_REGD != 0) begin : g_reg
        logic [CS*R-1:0] cke_q, cs_n_q;
        logic [R-1:0]    ras_n_q, cas_n_q, we_n_q;
        logic [BW*R-1:0] ba_q;
        logic [AW*R-1:0] addr_q;

        always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
            if (!ctl_reset_n) begin
                cke_q   <= '1;
                cs_n_q  <= '1;
                ras_n_q <= '1;
                cas_n_q <= '1;
                we_n_q  <= '1;
                ba_q    <= '0;
                addr_q  <= '0;
            end else begin
                cke_q   <= cke_d;
                cs_n_q  <= cs_n_d;
                ras_n_q <= ras_n_d;
                cas_n_q <= cas_n_d;
                we_n_q  <= we_n_d;
                ba_q    <= ba_d;
                addr_q  <= addr_d;
            end
        end

        assign afi_cke   = cke_q;
        assign afi_cs_n  = cs_n_q;
        assign afi_ras_n = ras_n_q;
        assign afi_cas_n = cas_n_q;
        assign afi_we_n  = we_n_q;
        assign afi_ba    = ba_q;
        assign afi_addr  = addr_q;
    end else begin : g_comb
        assign afi_cke   = cke_d;
        assign afi_cs_n  = cs_n_d;
        assign afi_ras_n = ras_n_d;
        assign afi_cas_n = cas_n_d;
        assign afi_we_n  = we_n_d;
        assign afi_ba    = ba_d;
        assign afi_addr  = addr_d;
    end
endmodule

// File: tb/tb_ddrx_addr_cmd_lp.sv
// Directed bench: full-rate DDR2 (2 chips, combinational) and
// half-rate DDR3 (1 chip, registered outputs) decoders.
module tb_ddrx_addr_cmd_lp;
    logic ctl_clk, ctl_reset_n, cal0, cal1;
    int   errors = 0;
    int   checks = 0;

    ddrx_addr_cmd_lp_if #(.CS_W(2), .BA_W(3), .ROW_W(13), .COL_W(10)) if0 ();
    ddrx_addr_cmd_lp_if #(.CS_W(1), .BA_W(3), .ROW_W(13), .COL_W(10)) if1 ();

    logic [3:0]  lp0;
    logic [1:0]  cke0, cs0;
    logic        ras0, cas0, we0, rstn0;
    logic [2:0]  ba0;
    logic [12:0] ad0;
    logic [22:0] v0;

    logic [1:0]  lp1, cke1, cs1, ras1, cas1, we1, rstn1;
    logic [5:0]  ba1;
    logic [25:0] ad1;
    logic [41:0] v1;

    logic [22:0] q0[$];
    logic [41:0] q1[$];

    assign v0 = {cke0, cs0, ras0, cas0, we0, ba0, ad0};
    assign v1 = {cke1, cs1, ras1, cas1, we1, ba1, ad1};

    ddrx_addr_cmd_lp #(
        .MEM_IF_CS_WIDTH(2), .MEM_TYPE("DDR2"), .DWIDTH_RATIO(2),
        .CTL_OUTPUT_REGD(0)
    ) u0 (
        .ctl_clk(ctl_clk), .ctl_reset_n(ctl_reset_n),
        .ctl_cal_success(cal0), .cmd(if0), .chip_lp_state(lp0),
        .afi_cke(cke0), .afi_cs_n(cs0), .afi_ras_n(ras0),
        .afi_cas_n(cas0), .afi_we_n(we0), .afi_rst_n(rstn0),
        .afi_ba(ba0), .afi_addr(ad0)
    );

    ddrx_addr_cmd_lp #(
        .MEM_IF_CS_WIDTH(1), .MEM_TYPE("DDR3"), .DWIDTH_RATIO(4),
        .CTL_OUTPUT_REGD(1)
    ) u1 (
        .ctl_clk(ctl_clk), .ctl_reset_n(ctl_reset_n),
        .ctl_cal_success(cal1), .cmd(if1), .chip_lp_state(lp1),
        .afi_cke(cke1), .afi_cs_n(cs1), .afi_ras_n(ras1),
        .afi_cas_n(cas1), .afi_we_n(we1), .afi_rst_n(rstn1),
        .afi_ba(ba1), .afi_addr(ad1)
    );

    initial begin
        ctl_clk = 1'b0;
        forever #5 ctl_clk = ~ctl_clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    function automatic logic [22:0] e0(input logic [1:0] cke,
        input logic [1:0] cs, input logic [2:0] rcw,
        input logic [2:0] ba, input logic [12:0] a);
        return {cke, cs, rcw, ba, a};
    endfunction

    function automatic logic [41:0] e1(input logic s, input logic [1:0] cke,
        input logic cs, input logic [2:0] rcw,
        input logic [2:0] ba, input logic [12:0] a);
        logic [1:0] c, r, ca, w;
        logic [5:0] b;
        logic [25:0] ad;
        c  = s ? {cs, 1'b1}     : {1'b1, cs};
        r  = s ? {rcw[2], 1'b1} : {1'b1, rcw[2]};
        ca = s ? {rcw[1], 1'b1} : {1'b1, rcw[1]};
        w  = s ? {rcw[0], 1'b1} : {1'b1, rcw[0]};
        b  = s ? {ba, 3'b0}     : {3'b0, ba};
        ad = s ? {a, 13'b0}     : {13'b0, a};
        return {cke, c, r, ca, w, b, ad};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge ctl_clk);
        #1;
    endtask

    task automatic set0(input logic [3:0] t, input logic [1:0] ch,
        input logic [2:0] ba, input logic [12:0] row,
        input logic [9:0] col, input logic ap, input logic zq);
        if0.cmd_type = t;
        if0.to_chip = ch;
        if0.to_bank_addr = ba;
        if0.to_row_addr = row;
        if0.to_col_addr = col;
        if0.do_auto_precharge = ap;
        if0.zq_long = zq;
    endtask

    task automatic set1(input logic [3:0] t, input logic s,
        input logic [2:0] ba, input logic [9:0] col,
        input logic ap, input logic bc, input logic zq);
        if1.cmd_type = t;
        if1.cmd_slot = s;
        if1.to_chip = 1'b1;
        if1.to_bank_addr = ba;
        if1.to_col_addr = col;
        if1.do_auto_precharge = ap;
        if1.do_burst_chop = bc;
        if1.zq_long = zq;
    endtask

    task automatic go0(input logic [22:0] exp, input string tag);
        logic [22:0] e;
        if0.cmd_valid = 1'b1;
        q0.push_back(exp);
        @(negedge ctl_clk);
        chk({tag, "_rdy"}, 64'(if0.cmd_ready), 64'd1);
        e = q0.pop_front();
        chk(tag, 64'(v0), 64'(e));
        cyc();
        if0.cmd_valid = 1'b0;
    endtask

    task automatic go1(input logic [41:0] exp, input string tag);
        logic [41:0] e;
        if1.cmd_valid = 1'b1;
        q1.push_back(exp);
        @(negedge ctl_clk);
        chk({tag, "_rdy"}, 64'(if1.cmd_ready), 64'd1);
        cyc();
        if1.cmd_valid = 1'b0;
        @(negedge ctl_clk);
        e = q1.pop_front();
        chk(tag, 64'(v1), 64'(e));
    endtask

    task automatic err0(input string tag);
        @(negedge ctl_clk);
        chk(tag, 64'(if0.cmd_err), 64'd1);
        cyc();
    endtask

    task automatic stall0(input int exp_n, input int limit, input string tag);
        int n;
        n = 0;
        while (if0.cmd_ready == 1'b0 && n < limit) begin
            n++;
            @(negedge ctl_clk);
        end
        chk(tag, 64'(n), 64'(exp_n));
        cyc();
    endtask

    initial begin
        ctl_reset_n = 1'b0;
        cal0 = 1'b1;
        cal1 = 1'b1;
        if0.cmd_valid = 1'b0;
        if0.cmd_slot = 1'b0;
        if0.do_burst_chop = 1'b0;
        set0(4'd0, 2'b00, 3'd0, 13'd0, 10'd0, 1'b0, 1'b0);
        if1.cmd_valid = 1'b0;
        if1.to_row_addr = '0;
        set1(4'd0, 1'b0, 3'd0, 10'd0, 1'b0, 1'b0, 1'b0);
        if1.to_chip = 1'b0;

        repeat (3) @(posedge ctl_clk);
        @(negedge ctl_clk);
        chk("rst_afi0", 64'(v0), 64'(e0(2'b11, 2'b11, 3'b111, 3'd0, 13'd0)));
        chk("rst_rdy0", 64'(if0.cmd_ready), 64'd0);
        chk("rst_err0", 64'(if0.cmd_err), 64'd0);
        chk("rst_lp0", 64'(lp0), 64'd0);
        chk("rst_rstn0", 64'(rstn0), 64'd1);
        chk("rst_afi1", 64'(v1), 64'(e1(1'b0, 2'b11, 1'b1, 3'b111, 3'd0, 13'd0)));
        chk("rst_rdy1", 64'(if1.cmd_ready), 64'd0);
        chk("rst_rstn1", 64'(rstn1), 64'd3);
        cyc();
        ctl_reset_n = 1'b1;
        cyc();

        set0(4'd1, 2'b01, 3'd2, 13'h1A5, 10'd0, 1'b0, 1'b0);
        go0(e0(2'b11, 2'b10, 3'b011, 3'd2, 13'h1A5), "act");
        set0(4'd2, 2'b10, 3'd5, 13'd0, 10'h155, 1'b1, 1'b0);
        go0(e0(2'b11, 2'b01, 3'b101, 3'd5, 13'h555), "rd_ap");
        set0(4'd5, 2'b11, 3'd3, 13'd0, 10'd0, 1'b0, 1'b0);
        go0(e0(2'b11, 2'b00, 3'b010, 3'd3, 13'h400), "prea");
        set0(4'd7, 2'b11, 3'd1, 13'h123, 10'd0, 1'b0, 1'b0);
        go0(e0(2'b11, 2'b00, 3'b000, 3'd1, 13'h123), "mrs");
        set0(4'd6, 2'b10, 3'd6, 13'd0, 10'd0, 1'b0, 1'b0);
        go0(e0(2'b11, 2'b01, 3'b001, 3'd0, 13'd0), "ref");

        set0(4'd8, 2'b01, 3'd0, 13'd0, 10'd0, 1'b0, 1'b1);
        go0(e0(2'b11, 2'b11, 3'b111, 3'd0, 13'd0), "zq_ddr2");
        @(negedge ctl_clk);
        chk("zq_err", 64'(if0.cmd_err), 64'd1);
        @(negedge ctl_clk);
        chk("zq_err_clr", 64'(if0.cmd_err), 64'd0);
        cyc();

        set0(4'd9, 2'b01, 3'd0, 13'd0, 10'd0, 1'b0, 1'b0);
        go0(e0(2'b10, 2'b11, 3'b111, 3'd0, 13'd0), "pdn");
        @(negedge ctl_clk);
        chk("pdn_idle", 64'(v0), 64'(e0(2'b10, 2'b11, 3'b111, 3'd0, 13'd0)));
        chk("pdn_lp", 64'(lp0), 64'h1);
        stall0(3, 20, "pdn_res");

        set0(4'd11, 2'b01, 3'd0, 13'd0, 10'd0, 1'b0, 1'b0);
        go0(e0(2'b11, 2'b11, 3'b111, 3'd0, 13'd0), "pdn_exit");
        @(negedge ctl_clk);
        chk("pdn_exit_lp", 64'(lp0), 64'h0);
        stall0(3, 20, "txp");

        set0(4'd10, 2'b10, 3'd0, 13'd0, 10'd0, 1'b0, 1'b0);
        go0(e0(2'b01, 2'b01, 3'b001, 3'd0, 13'd0), "srf");
        @(negedge ctl_clk);
        chk("srf_lp", 64'(lp0), 64'h8);
        stall0(3, 20, "srf_res");

        set0(4'd2, 2'b10, 3'd5, 13'd0, 10'h00F, 1'b0, 1'b0);
        go0(e0(2'b01, 2'b11, 3'b111, 3'd0, 13'd0), "rd_srf");
        @(negedge ctl_clk);
        chk("rd_srf_err", 64'(if0.cmd_err), 64'd1);
        chk("rd_srf_lp", 64'(lp0), 64'h8);
        cyc();

        set0(4'd11, 2'b01, 3'd0, 13'd0, 10'd0, 1'b0, 1'b0);
        go0(e0(2'b01, 2'b11, 3'b111, 3'd0, 13'd0), "exit_act");
        err0("exit_act_err");

        set0(4'd11, 2'b10, 3'd0, 13'd0, 10'd0, 1'b0, 1'b0);
        go0(e0(2'b11, 2'b11, 3'b111, 3'd0, 13'd0), "srf_exit");
        @(negedge ctl_clk);
        chk("srf_exit_lp", 64'(lp0), 64'h0);
        stall0(256, 400, "txs");

        set0(4'd1, 2'b00, 3'd2, 13'd5, 10'd0, 1'b0, 1'b0);
        go0(e0(2'b11, 2'b11, 3'b111, 3'd0, 13'd0), "nochip");
        err0("nochip_err");

        set1(4'd3, 1'b0, 3'd4, 10'h3F8, 1'b1, 1'b1, 1'b0);
        go1(e1(1'b0, 2'b11, 1'b0, 3'b100, 3'd4, 13'h07F8), "wr_ddr3");
        cyc();
        set1(4'd2, 1'b1, 3'd1, 10'h010, 1'b0, 1'b0, 1'b0);
        go1(e1(1'b1, 2'b11, 1'b0, 3'b101, 3'd1, 13'h1010), "rd_slot1");
        chk("rd_slot1_cs", 64'(cs1), 64'h1);
        cyc();
        set1(4'd8, 1'b0, 3'd5, 10'd0, 1'b0, 1'b0, 1'b1);
        go1(e1(1'b0, 2'b11, 1'b0, 3'b110, 3'd0, 13'h0400), "zq_ddr3");
        cyc();

        set1(4'd10, 1'b1, 3'd0, 10'd0, 1'b0, 1'b0, 1'b0);
        go1(e1(1'b1, 2'b01, 1'b0, 3'b001, 3'd0, 13'd0), "srf_slot1");
        chk("srf1_lp", 64'(lp1), 64'h2);
        cyc();
        @(negedge ctl_clk);
        chk("srf1_idle", 64'(v1), 64'(e1(1'b0, 2'b00, 1'b1, 3'b111, 3'd0, 13'd0)));
        chk("srf1_rdy", 64'(if1.cmd_ready), 64'd0);
        cyc();
        cal1 = 1'b0;
        cyc();
        @(negedge ctl_clk);
        chk("cal_afi", 64'(v1), 64'(e1(1'b0, 2'b11, 1'b1, 3'b111, 3'd0, 13'd0)));
        chk("cal_lp", 64'(lp1), 64'h0);
        chk("cal_rdy", 64'(if1.cmd_ready), 64'd0);
        cyc();
        cal1 = 1'b1;
        @(negedge ctl_clk);
        chk("cal_back_rdy", 64'(if1.cmd_ready), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
